rgb_pwm_driver: RTL

//  Downstream stage of the lights selector: consumes the 24-bit RGB code on

---
 rtl/rgb_pwm_driver.sv | 74 +++++++
 1 files changed

// File: rtl/rgb_pwm_driver.sv
// Three-channel PWM driver for an RGB LED. Duty values are latched only at
// period boundaries so a colour change never truncates or extends a pulse.
module rgb_pwm_driver #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [23:0] light,
  output logic        pwm_r,
  output logic        pwm_g,
  output logic        pwm_b,
  output logic        frame_strobe
);

  // Keep the prescaler at least one bit wide so PRESCALE=1 still elaborates.
  localparam int unsigned    PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [7:0]     CNT_LAST = 8'd254;

  logic [PW-1:0] pre;
  logic [7:0]    cnt;
  logic [7:0]    duty_r;
  logic [7:0]    duty_g;
  logic [7:0]    duty_b;
  logic          tick;
  logic          wrap;

  always_comb begin
    tick = (pre == PRE_LAST);
    wrap = enable & tick & (cnt == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre          <= '0;
      cnt          <= '0;
      duty_r       <= '0;
      duty_g       <= '0;
      duty_b       <= '0;
      pwm_r        <= 1'b0;
      pwm_g        <= 1'b0;
      pwm_b        <= 1'b0;
      frame_strobe <= 1'b0;
    end else if (!enable) begin
      // While idle the duty registers track the input, so the first period
      // after enable rises uses the last colour seen.
      pre          <= '0;
      cnt          <= '0;
      duty_r       <= light[23:16];
      duty_g       <= light[15:8];
      duty_b       <= light[7:0];
      pwm_r        <= 1'b0;
      pwm_g        <= 1'b0;
      pwm_b        <= 1'b0;
      frame_strobe <= 1'b0;
    end else begin
      pre <= tick ? '0 : pre + PW'(1);
      if (tick) begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 8'd1;
      end
      if (wrap) begin
        duty_r <= light[23:16];
        duty_g <= light[15:8];
        duty_b <= light[7:0];
      end
      frame_strobe <= wrap;
      pwm_r        <= (cnt < duty_r);
      pwm_g        <= (cnt < duty_g);
      pwm_b        <= (cnt < duty_b);
    end
  end

endmodule
